// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter (ram_arb_2port, rr_arb2).
// Optional build macro: RAM_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
package ram_arb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;
    localparam int RD_LAT_MAX = 4;
    // Latency counter must hold RD_LAT_MAX itself, not just RD_LAT_MAX-1.
    localparam int LAT_CNT_W  = $clog2(RD_LAT_MAX + 1);

    typedef logic req_id_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

endpackage

// File: rtl/ram_arb_2port_rr_arb2.sv
// Two-way winner pick. Round-robin with a toggling pointer by default;
// fixed priority (requester 0 always wins) when RAM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
    import ram_arb_pkg::*;
(
`ifndef RAM_ARB_FIXED_PRIO_EN
    input  logic    clk,
    input  logic    rst,
    input  logic    update,
`endif
    input  logic    req0,
    input  logic    req1,
    output logic    vld,
    output req_id_t win_id
);

    assign vld = req0 | req1;

`ifdef RAM_ARB_FIXED_PRIO_EN

    always_comb begin
        win_id = req0 ? 1'b0 : 1'b1;
    end

`else

    logic rr_ptr;

    always_comb begin
        win_id = 1'b0;
        if (req0 && req1) begin
            win_id = rr_ptr;
        end else if (req1) begin
            win_id = 1'b1;
        end
    end

    // The pointer only moves when contention was actually resolved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= 1'b0;
        end else if (update && req0 && req1) begin
            rr_ptr <= ~rr_ptr;
        end
    end

`endif

endmodule

// File: rtl/ram_arb_2port.sv
// Arbiter/sequencer owning a single-port RAM on behalf of two requesters.
// Optional build macro: RAM_ARB_FIXED_PRIO_EN (fixed priority, requester 0 wins contention).
module ram_arb_2port
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_datain,
    input  logic [DATA_W-1:0] ram_dataout
);

    state_t                 state;
    state_t                 state_nxt;
    logic                   latch;
    logic                   arb_vld;
    req_id_t                arb_id;
    logic                   cmd_we;
    logic [ADDR_W-1:0]      cmd_addr;
    logic [DATA_W-1:0]      cmd_wdata;
    req_id_t                cmd_id;
    logic [LAT_CNT_W-1:0]   lat_cnt;
    logic                   lat_done;

    rr_arb2 u_arb (
`ifndef RAM_ARB_FIXED_PRIO_EN
        .clk    (clk),
        .rst    (rst),
        .update (latch),
`endif
        .req0   (req0),
        .req1   (req1),
        .vld    (arb_vld),
        .win_id (arb_id)
    );

    assign lat_done = (lat_cnt == LAT_CNT_W'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Requests are only looked at in IDLE; every other state runs to completion.
    always_comb begin
        state_nxt = state;
        latch     = 1'b0;
        case (state)
            IDLE: begin
                if (arb_vld) begin
                    state_nxt = ISSUE;
                    latch     = 1'b1;
                end
            end
            ISSUE: begin
                state_nxt = cmd_we ? IDLE : RDWAIT;
            end
            RDWAIT: begin
                if (lat_done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_id    <= 1'b0;
        end else if (latch) begin
            cmd_we    <= arb_id ? we1    : we0;
            cmd_addr  <= arb_id ? addr1  : addr0;
            cmd_wdata <= arb_id ? wdata1 : wdata0;
            cmd_id    <= arb_id;
        end
    end

    // Counter is loaded as the read leaves ISSUE, so it hits 0 on edge +1+RD_LAT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= '0;
        end else if (state == ISSUE && !cmd_we) begin
            lat_cnt <= LAT_CNT_W'(RD_LAT);
        end else if (state == RDWAIT) begin
            lat_cnt <= lat_cnt - LAT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            if (state == RDWAIT && lat_done) begin
                if (cmd_id) begin
                    rvalid1 <= 1'b1;
                    rdata1  <= ram_dataout;
                end else begin
                    rvalid0 <= 1'b1;
                    rdata0  <= ram_dataout;
                end
            end
        end
    end

    assign gnt0        = (state == ISSUE) && !cmd_id;
    assign gnt1        = (state == ISSUE) &&  cmd_id;
    assign ram_en      = (state == ISSUE) &&  cmd_we;
    assign ram_address = cmd_addr;
    assign ram_datain  = cmd_wdata;

endmodule
